mem_data_arbiter: RTL and testbench
===================================

Name: mem_data_arbiter

Overview:
- Two-port arbiter for the word-addressed data memory (memData).
- Port 0 is the core load/store unit; port 1 is a secondary master (boot loader / debug).
- Grants one access at a time, round-robin. Latches the winner's command and drives the memory's single write/read address pair.
- Captures read data and returns it with a one-cycle valid pulse to the requester that issued it.

Parameters:
- XLEN, 32, data width; must match memData.
- ADDRESSLEN, 32, byte-address width; must match memData.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDRESSLEN  port 0 byte address.
- req0_wdata  in  XLEN  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_rvalid  out  1  port 0 read data valid (1-cycle pulse).
- req0_rdata  out  XLEN  port 0 read data.
- req1_*  (same set of signals as port 0)  port 1.
- mem_we  out  1  to memData writeEnabled.
- mem_waddr  out  ADDRESSLEN  to memData writeAddress.
- mem_raddr  out  ADDRESSLEN  to memData readAddress.
- mem_wdata  out  XLEN  to memData data.
- mem_rdata  in  XLEN  from memData out. memData updates it on negedge.
- err  out  1  alignment fault pulse; only with MEM_ARB_ALIGN_CHECK_EN, otherwise tied to 0.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state = IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs 0.
  - Latched address, data, we and owner = 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - grant is combinational. A single valid wins; if both are valid, the port != last_grant wins.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. There is no ready without valid.
  - On ready: latch addr/wdata/we, set owner = N and last_grant = N, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_waddr = mem_raddr = latched addr; mem_wdata = latched data.
  - mem_we = latched we. It is high only in ACCESS, so exactly one write strobe per accepted write.
  - memData samples mem_raddr on the negedge inside ACCESS. The arbiter registers mem_rdata into reqN_rdata at the closing posedge.
  - Return to IDLE unconditionally.
- Read response:
  - reqN_rvalid = 1 for exactly one cycle, the cycle after ACCESS, and only for reads by owner N.
  - reqN_rdata holds its value until the next read by that port.
- Latency:
  - Accept at edge T; ACCESS in cycle T+1; rvalid in cycle T+2.
  - New accept is possible in the same cycle as rvalid, giving a peak throughput of 1 access per 2 cycles.
- Outside ACCESS: mem_we = 0; mem_* address and data hold their last values (no glitching to 0).
- Writes produce no rvalid; completion is implied by the ready handshake.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1… No port waits more than one access.
- Requester obligation: hold valid/we/addr/wdata stable until ready. The arbiter samples only on the ready edge; a request dropped before ready is simply lost, with no side effects.
- Reset mid-ACCESS: mem_we drops asynchronously and immediately. Pending rvalid is discarded. The memory contents are not touched by the arbiter.
- Address passes through at full width; memData performs word indexing with addr[ADDRESSLEN-1:2].

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - In ACCESS, if latched addr[1:0] != 0: force mem_we = 0 and pulse err for 1 cycle, in the rvalid slot.
  - For a misaligned read: rvalid still pulses with rdata = 0, so requesters never hang.
- Undefined: err tied to 0; low address bits are ignored (the memory truncates them).

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS};
  - port-id type (1 bit);
  - constant WORD_OFFSET_BITS = 2.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin picker taking valid[1:0] and last_grant and producing grant_id and grant_any.

Test Plan:
- Reset: assert rst mid-ACCESS with req0 writing 0xDEADBEEF to 0x8 -> mem_we falls immediately; all outputs 0; after release, port 0 wins the first tie.
- Single write then read on port 0 (write 0x12345678 @0x4, then read 0x4) -> exactly one mem_we cycle; req0_rvalid 2 cycles after accept with rdata 0x12345678; req1_rvalid stays 0.
- Contention: both ports hold reads (port 0 @0x0, port 1 @0x4) for 8 cycles -> grants alternate 0,1,0,1; each rvalid goes to the correct port with that port's word.
- Back-to-back: accept in the same cycle as the previous rvalid -> no bubble beyond 2 cycles per access; rdata of the earlier read is not overwritten before its rvalid.
- Write/read same address from different ports (port 1 writes 0xA5A5A5A5 @0xC, port 0 reads 0xC next) -> port 0 reads 0xA5A5A5A5.
- With MEM_ARB_ALIGN_CHECK_EN: port 0 writes to 0x6 -> err pulses 1 cycle, mem_we never asserted, memory word 0x4 unchanged; misaligned read -> rvalid with rdata 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port data-memory arbiter.
//   state_t          : arbiter FSM states (IDLE, ACCESS)
//   port_id_t        : requester index (0 = load/store unit, 1 = secondary master)
//   WORD_OFFSET_BITS : byte-offset bits inside a memory word
package mem_arb_pkg;
    typedef enum logic {IDLE, ACCESS} state_t;
    typedef logic port_id_t;
    localparam int WORD_OFFSET_BITS = 2;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker.
//   valid[1:0] : request lines of port 1 / port 0
//   last_grant : port that won the previous arbitration
//   grant_id   : winning port (meaningful only when grant_any)
//   grant_any  : at least one request is pending
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  port_id_t   last_grant,
    output port_id_t   grant_id,
    output logic       grant_any
);
    // A lone requester wins outright; on a tie the port that did not win last time wins.
    always_comb begin
        grant_any = |valid;
        grant_id  = (&valid) ? ~last_grant : valid[1];
    end
endmodule

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: round-robin arbiter sharing memData between two masters.
//   clk, rst                : clock, asynchronous active-high reset
//   reqN_valid/we/addr/wdata: request from port N (0 = LSU, 1 = boot/debug)
//   reqN_ready              : request of port N accepted this cycle
//   reqN_rvalid/rdata       : one-cycle read response pulse and held read data
//   mem_we/waddr/raddr/wdata: memData write strobe, addresses and write data
//   mem_rdata               : memData read data (updated by memData on negedge)
//   err                     : misalignment pulse when MEM_ARB_ALIGN_CHECK_EN is defined, else 0
module mem_data_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDRESSLEN-1:0] req0_addr,
    input  logic [XLEN-1:0]       req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [XLEN-1:0]       req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDRESSLEN-1:0] req1_addr,
    input  logic [XLEN-1:0]       req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [XLEN-1:0]       req1_rdata,
    output logic                  mem_we,
    output logic [ADDRESSLEN-1:0] mem_waddr,
    output logic [ADDRESSLEN-1:0] mem_raddr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  err
);
    state_t                state, state_n;
    port_id_t              last_grant, owner, grant_id;
    logic                  grant_any, accept, lat_we, mis, rd_done;
    logic [ADDRESSLEN-1:0] lat_addr;
    logic [XLEN-1:0]       lat_data;

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant_id   (grant_id),
        .grant_any  (grant_any)
    );

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign mis = lat_addr[WORD_OFFSET_BITS-1:0] != '0;
`else
    assign mis = 1'b0;
`endif

    // Memory-side address/data come straight from the latch, so they hold between accesses.
    assign mem_waddr = lat_addr;
    assign mem_raddr = lat_addr;
    assign mem_wdata = lat_data;

    always_comb begin
        accept     = state == IDLE && grant_any;
        req0_ready = accept && grant_id == 1'b0;
        req1_ready = accept && grant_id == 1'b1;
        // Derived from the async-reset state, so the strobe drops the moment rst rises.
        mem_we     = state == ACCESS && lat_we && !mis;
        rd_done    = state == ACCESS && !lat_we;
        state_n    = accept ? ACCESS : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_rvalid <= rd_done && owner == 1'b0;
            req1_rvalid <= rd_done && owner == 1'b1;
            if (rd_done && owner == 1'b0) req0_rdata <= mis ? '0 : mem_rdata;
            if (rd_done && owner == 1'b1) req1_rdata <= mis ? '0 : mem_rdata;
            if (accept) begin
                lat_we     <= grant_id ? req1_we    : req0_we;
                lat_addr   <= grant_id ? req1_addr  : req0_addr;
                lat_data   <= grant_id ? req1_wdata : req0_wdata;
                owner      <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    // Fault pulse lands in the same slot a read response would.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err <= 1'b0;
        else     err <= state == ACCESS && mis;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_data_arbiter.sv
// tb_mem_data_arbiter: directed + random checks of mem_data_arbiter against a transaction-level model.
module tb_mem_data_arbiter;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, init = 1'b1;
    logic        req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic        req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic        mem_we, err;
    logic [31:0] mem_waddr, mem_raddr, mem_wdata, mem_rdata;

    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    int n_vec = 0, n_bad = 0;

    // Model state: one outstanding access and one outstanding response, tagged with the cycle they occur in.
    int          cyc, free_at;
    logic        m_last, acc0, acc1;
    logic        acc_pend, acc_we, acc_port;
    int          acc_cyc;
    logic [31:0] acc_addr, acc_data;
    logic        rsp_pend, rsp_rd, rsp_port, rsp_err;
    int          rsp_cyc;
    logic [31:0] exp_rdata [2];
    logic [31:0] last_addr, last_data;

    mem_data_arbiter #(.XLEN(32), .ADDRESSLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // memData stand-in: write on posedge, read on negedge, word indexed.
    always @(posedge clk) begin
        if (init) for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        else if (mem_we) mem[mem_waddr[5:2]] <= mem_wdata;
    end
    always @(negedge clk) mem_rdata <= mem[mem_raddr[5:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        chk1({tag, "_ready0"}, req0_ready, 1'b0);
        chk1({tag, "_ready1"}, req1_ready, 1'b0);
        chk1({tag, "_rvalid0"}, req0_rvalid, 1'b0);
        chk1({tag, "_rvalid1"}, req1_rvalid, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk({tag, "_rdata0"}, req0_rdata, 32'h0);
        chk({tag, "_rdata1"}, req1_rdata, 32'h0);
        chk({tag, "_waddr"}, mem_waddr, 32'h0);
        chk({tag, "_raddr"}, mem_raddr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
    endtask

    task automatic drive_idle();
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    endtask

    // Holds rst across two edges, then restarts the model from its reset picture.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0; free_at = 0; m_last = 1'b1;
        acc_pend = 0; rsp_pend = 0; acc0 = 0; acc1 = 0;
        exp_rdata[0] = 0; exp_rdata[1] = 0;
        last_addr = 0; last_data = 0;
    endtask

    // One clock cycle: drive, check handshake, clock, update model, check memory side and responses.
    task automatic step(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic any, g, mis, in_acc, r;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        #1;
        any = cyc >= free_at && (v0 || v1);
        g   = (v0 && v1) ? ~m_last : v1;
        chk1("ready0", req0_ready, any && !g);
        chk1("ready1", req1_ready, any && g);
        @(posedge clk);
        if (acc_pend && acc_cyc == cyc) begin
            acc_pend = 0;
            mis = ALIGN && acc_addr[1:0] != 2'b00;
            if (acc_we && !mis) ref_mem[acc_addr[5:2]] = acc_data;
            if (!acc_we) exp_rdata[acc_port] = mis ? 32'h0 : ref_mem[acc_addr[5:2]];
            rsp_pend = 1; rsp_cyc = cyc + 1; rsp_port = acc_port; rsp_rd = !acc_we; rsp_err = mis;
        end
        acc0 = any && !g;
        acc1 = any && g;
        if (any) begin
            acc_pend = 1; acc_cyc = cyc + 1; acc_port = g;
            acc_we   = g ? w1 : w0;
            acc_addr = g ? a1 : a0;
            acc_data = g ? d1 : d0;
            m_last   = g;
            free_at  = cyc + 2;
        end
        cyc++;
        #1;
        in_acc = acc_pend && acc_cyc == cyc;
        if (in_acc) begin last_addr = acc_addr; last_data = acc_data; end
        mis = ALIGN && acc_addr[1:0] != 2'b00;
        chk1("mem_we", mem_we, in_acc && acc_we && !mis);
        chk("mem_waddr", mem_waddr, last_addr);
        chk("mem_raddr", mem_raddr, last_addr);
        chk("mem_wdata", mem_wdata, last_data);
        r = rsp_pend && rsp_cyc == cyc;
        chk1("rvalid0", req0_rvalid, r && rsp_rd && rsp_port == 1'b0);
        chk1("rvalid1", req1_rvalid, r && rsp_rd && rsp_port == 1'b1);
        chk("rdata0", req0_rdata, exp_rdata[0]);
        chk("rdata1", req1_rdata, exp_rdata[1]);
        chk1("err", err, r && rsp_err);
        if (r) rsp_pend = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Single transfer on port p, held until accepted (bounded), then drained.
    task automatic xfer(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int k = 0;
        do begin
            step(!p, we, a, d, p, we, a, d);
            k++;
        end while (!(acc0 || acc1) && k < 8);
        chk1("xfer_accept", p ? acc1 : acc0, 1'b1);
        idle(2);
    endtask

    initial begin
        logic [31:0] seq_addr [4];
        logic        pv [2];
        logic        pw [2];
        logic [31:0] pa [2];
        logic [31:0] pd [2];
        int          idx;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        cyc = 0;
        drive_idle();
        #1 check_zero("reset");
        @(posedge clk);
        #1 init = 1'b0;
        do_reset();
        check_zero("post_reset");

        // Reset while a write is in flight: strobe must fall at once and memory stays intact.
        step(1, 1, 32'h8, 32'hDEAD_BEEF, 0, 0, 0, 0);
        #2;
        drive_idle();
        rst = 1'b1;
        #1 check_zero("mid_access_reset");
        do_reset();
        step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        chk1("first_tie_port0", acc0, 1'b1);
        idle(2);

        xfer(0, 1, 32'h4, 32'h1234_5678);
        xfer(0, 0, 32'h4, 0);

        repeat (8) step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        idle(2);

        seq_addr[0] = 32'h0; seq_addr[1] = 32'h8; seq_addr[2] = 32'h4; seq_addr[3] = 32'h10;
        idx = 0;
        repeat (10) begin
            step(idx < 4, 0, seq_addr[idx < 4 ? idx : 0], 0, 0, 0, 0, 0);
            if (acc0) idx++;
        end
        chk("stream_done", 32'(idx), 32'd4);
        idle(2);

        xfer(1, 1, 32'hC, 32'hA5A5_A5A5);
        xfer(0, 0, 32'hC, 0);

        xfer(0, 1, 32'h6, 32'hCAFE_F00D);
        xfer(0, 0, 32'h6, 0);
        xfer(1, 0, 32'h4, 0);

        // Random traffic: each port holds its request until accepted.
        for (int p = 0; p < 2; p++) begin pv[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; end
        repeat (400) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 2) != 0) begin
                    pv[p] = 1;
                    pw[p] = 1'($urandom);
                    pa[p] = {26'b0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
                    pd[p] = $urandom;
                end
            end
            step(pv[0], pw[0], pa[0], pd[0], pv[1], pw[1], pa[1], pd[1]);
            if (acc0) pv[0] = 0;
            if (acc1) pv[1] = 0;
        end
        idle(3);

        for (int i = 0; i < 16; i++) chk("mem_word", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
